// File: rtl/risc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : risc_pkg
//  Purpose  : Shared tiny-RISC definitions. These are the opcode encodings
//             used by the instruction sequencer and the downstream decoder,
//             plus the sequencer state type.
//  Contents : OP_* opcode localparams (6-bit), seq_state_t enum
//  Revision : 1.0  initial release
// ============================================================================
package risc_pkg;

    localparam int OPCODE_BITS = 6;

    localparam logic [OPCODE_BITS-1:0] OP_NOP     = 6'b000000;
    localparam logic [OPCODE_BITS-1:0] OP_LOADA   = 6'b000001;
    localparam logic [OPCODE_BITS-1:0] OP_LOADB   = 6'b000010;
    localparam logic [OPCODE_BITS-1:0] OP_ADD     = 6'b000011;
    localparam logic [OPCODE_BITS-1:0] OP_READOUT = 6'b000100;
    localparam logic [OPCODE_BITS-1:0] OP_JMP     = 6'b000101;
    localparam logic [OPCODE_BITS-1:0] OP_HALT    = 6'b111111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// ============================================================================
//  Module   : prog_mem
//  Purpose  : Program store for the instruction sequencer. DEPTH x WIDTH
//             flop array with one synchronous write port and one
//             asynchronous (combinational) read port. Contents are not reset.
//  Ports    : clk            rising-edge clock
//             we/waddr/wdata synchronous write port
//             raddr/rdata    combinational read port
//  Revision : 1.0  initial release
// ============================================================================
module prog_mem #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 14,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // No reset on the array: program contents survive rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule
`default_nettype wire

// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Program sequencer feeding the tiny-RISC decoder. It holds a
//             loadable program memory and a PC, and issues one
//             {opcode, operand} per valid/ready handshake until a HALT word.
//  Ports    : clk, rst (async, active-high)
//             prog_we/prog_addr/prog_wdata  program load (IDLE/HALT only)
//             start, abort                  run control
//             instr_valid/instr_ready       downstream handshake
//             opcode, operand, pc           issued instruction and its address
//             busy (FETCH/ISSUE), done (HALT)
//  Config   : `define INSTR_SEQUENCER_JUMP_EN to consume JMP internally
//             (pc <= operand[ADDR_W-1:0], one bubble per jump). When it is
//             undefined, JMP is issued downstream like any other opcode.
//  Revision : 1.0  initial release
// ============================================================================
module instr_sequencer
    import risc_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int DATA_W   = 8,
    parameter int OPCODE_W = 6,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       prog_we,
    input  logic [ADDR_W-1:0]          prog_addr,
    input  logic [OPCODE_W+DATA_W-1:0] prog_wdata,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       instr_ready,
    output logic                       instr_valid,
    output logic [OPCODE_W-1:0]        opcode,
    output logic [DATA_W-1:0]          operand,
    output logic [ADDR_W-1:0]          pc,
    output logic                       busy,
    output logic                       done
);

    localparam int WORD_W = OPCODE_W + DATA_W;

    seq_state_t          state;

    logic [ADDR_W-1:0]   pc_inc;
    logic [ADDR_W-1:0]   rd_addr;
    logic [WORD_W-1:0]   rd_word;
    logic [OPCODE_W-1:0] rd_op;
    logic [DATA_W-1:0]   rd_opd;
    logic                rd_is_halt;
    logic                rd_is_jmp;
    logic [ADDR_W-1:0]   jmp_target;
    logic                mem_we;
    logic                accept;

    // PC arithmetic wraps naturally at DEPTH because DEPTH is a power of two.
    assign pc_inc = pc + ADDR_W'(1);

    // In FETCH the word at pc is needed. In ISSUE the only time the read
    // data matters is on accept, when the following word must be loaded in
    // the same edge, so the single read port looks one ahead.
    assign rd_addr = (state == ISSUE) ? pc_inc : pc;

    // Writes are only honoured while nothing is executing.
    assign mem_we = prog_we && ((state == IDLE) || (state == HALT));

    prog_mem #(
        .DEPTH  (DEPTH),
        .WIDTH  (WORD_W),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    assign rd_op      = rd_word[WORD_W-1 -: OPCODE_W];
    assign rd_opd     = rd_word[DATA_W-1:0];
    assign rd_is_halt = (rd_op == OP_HALT);
    assign jmp_target = rd_opd[ADDR_W-1:0];

`ifdef INSTR_SEQUENCER_JUMP_EN
    assign rd_is_jmp = (rd_op == OP_JMP);
`else
    assign rd_is_jmp = 1'b0;
`endif

    assign accept = instr_valid && instr_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= '0;
            opcode      <= '0;
            operand     <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else if (abort) begin
            // abort outranks start and accept; opcode/operand simply hold.
            state       <= IDLE;
            pc          <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc    <= '0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    if (rd_is_halt) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= HALT;
                    end else if (rd_is_jmp) begin
                        // Jump chains (including a jump to itself) keep
                        // re-fetching with instr_valid low.
                        pc    <= jmp_target;
                    end else begin
                        opcode      <= rd_op;
                        operand     <= rd_opd;
                        instr_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (accept) begin
                        if (rd_is_halt) begin
                            pc          <= pc_inc;
                            instr_valid <= 1'b0;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= HALT;
                        end else if (rd_is_jmp) begin
                            // One bubble: back to FETCH at the target.
                            pc          <= jmp_target;
                            instr_valid <= 1'b0;
                            state       <= FETCH;
                        end else begin
                            // Back-to-back issue, one instruction per cycle.
                            pc      <= pc_inc;
                            opcode  <= rd_op;
                            operand <= rd_opd;
                        end
                    end
                end

                HALT: begin
                    if (start) begin
                        pc    <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= FETCH;
                    end else if (prog_we) begin
                        // Reloading a halted program drops back to IDLE.
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_sequencer
//  Purpose  : Directed self-checking bench for instr_sequencer (DEPTH=16,
//             DATA_W=8). Status vector compared throughout is
//             {instr_valid, busy, done, pc[3:0], opcode[5:0], operand[7:0]}.
//  Revision : 1.0  initial release
// ============================================================================
module tb_instr_sequencer;
    import risc_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        prog_we;
    logic [3:0]  prog_addr;
    logic [13:0] prog_wdata;
    logic        start;
    logic        abort;
    logic        instr_ready;
    logic        instr_valid;
    logic [5:0]  opcode;
    logic [7:0]  operand;
    logic [3:0]  pc;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    // Accepted {opcode, operand} pairs, in issue order.
    logic [13:0] acc_q[$];

    instr_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_wdata  (prog_wdata),
        .start       (start),
        .abort       (abort),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .opcode      (opcode),
        .operand     (operand),
        .pc          (pc),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Inputs only change #1 after a rising edge, so the negedge view of
    // valid/ready is exactly what the next rising edge will accept.
    always @(negedge clk) begin
        if (!rst && !abort && instr_valid && instr_ready) begin
            acc_q.push_back({opcode, operand});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [5:0] op, input logic [7:0] d);
        prog_we    = 1'b1;
        prog_addr  = a;
        prog_wdata = {op, d};
        tick();
        prog_we    = 1'b0;
    endtask

    task automatic load_basic();
        load(4'd0, OP_LOADA, 8'h05);
        load(4'd1, OP_LOADB, 8'h07);
        load(4'd2, OP_ADD,   8'h00);
        load(4'd3, OP_HALT,  8'h00);
    endtask

    task automatic test_reset();
        rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
        start = 1'b0; abort = 1'b0; instr_ready = 1'b0;
        tick();
        tick();
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== 21'h0) begin
            failures++;
            $display("FAIL reset_state: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, 21'h0);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [13:0] exp_acc [3];
        logic [20:0] exp_s;
        exp_acc = '{{OP_LOADA, 8'h05}, {OP_LOADB, 8'h07}, {OP_ADD, 8'h00}};
        acc_q.delete();
        instr_ready = 1'b1;
        load_basic();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_s = {1'b0, 1'b1, 1'b0, 4'd0, 6'h00, 8'h00};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL basic_fetch_cycle: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        tick();
        exp_s = {1'b1, 1'b1, 1'b0, 4'd0, OP_LOADA, 8'h05};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL basic_first_issue: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        tick();
        exp_s = {1'b1, 1'b1, 1'b0, 4'd1, OP_LOADB, 8'h07};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL basic_second_issue: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        tick();
        exp_s = {1'b1, 1'b1, 1'b0, 4'd2, OP_ADD, 8'h00};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL basic_third_issue: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        tick();
        exp_s = {1'b0, 1'b0, 1'b1, 4'd3, OP_ADD, 8'h00};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL basic_halt: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        checks++;
        if (acc_q.size() != 3) begin
            failures++;
            $display("FAIL basic_accept_count: got %0d expected 3", acc_q.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < acc_q.size()) begin
                checks++;
                if (acc_q[i] !== exp_acc[i]) begin
                    failures++;
                    $display("FAIL basic_stream[%0d]: got %h expected %h", i, acc_q[i], exp_acc[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [20:0] exp_s;
        acc_q.delete();
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                // LOADA presented
        tick();                // LOADA accepted, LOADB presented
        instr_ready = 1'b0;
        exp_s = {1'b1, 1'b1, 1'b0, 4'd1, OP_LOADB, 8'h07};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
                failures++;
                $display("FAIL stall_hold[%0d]: got %h expected %h", i,
                         {instr_valid, busy, done, pc, opcode, operand}, exp_s);
            end
            tick();
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done_timeout: got done=%b expected 1", done);
        end
        checks++;
        if (acc_q.size() != 3) begin
            failures++;
            $display("FAIL stall_accept_count: got %0d expected 3", acc_q.size());
        end
    endtask

    task automatic test_write_drop();
        logic [20:0] exp_s;
        acc_q.delete();
        instr_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();                // LOADA presented, held by ready=0
        load(4'd2, OP_HALT, 8'h00);   // must be dropped while issuing
        exp_s = {1'b1, 1'b1, 1'b0, 4'd0, OP_LOADA, 8'h05};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL drop_hold: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        instr_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) tick();
        exp_s = {1'b0, 1'b0, 1'b1, 4'd3, OP_ADD, 8'h00};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL drop_mem_unchanged: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        checks++;
        if (acc_q.size() != 3) begin
            failures++;
            $display("FAIL drop_accept_count: got %0d expected 3", acc_q.size());
        end
        load(4'd2, OP_ADD, 8'h00);    // write in HALT
        checks++;
        if ({instr_valid, busy, done} !== 3'b000) begin
            failures++;
            $display("FAIL halt_write_clears_done: got %b expected 000", {instr_valid, busy, done});
        end
    endtask

    task automatic test_wrap();
        logic [20:0] exp_s;
        for (int a = 0; a < 16; a++) load(4'(a), OP_NOP, 8'(a));
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) begin
            exp_s = {1'b1, 1'b1, 1'b0, 4'(i % 16), OP_NOP, 8'(i % 16)};
            checks++;
            if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
                failures++;
                $display("FAIL wrap_issue[%0d]: got %h expected %h", i,
                         {instr_valid, busy, done, pc, opcode, operand}, exp_s);
            end
            tick();
        end
        // pc=4 presented and ready=1: abort must beat the accept.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_s = {1'b0, 1'b0, 1'b0, 4'd0, OP_NOP, 8'h04};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL wrap_abort: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
    endtask

    task automatic test_start_abort();
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({instr_valid, busy, done, pc} !== 7'h00) begin
                failures++;
                $display("FAIL start_abort_idle[%0d]: got %h expected 00", i,
                         {instr_valid, busy, done, pc});
            end
            tick();
        end
    endtask

    task automatic test_async_rst();
        logic [20:0] exp_s;
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        instr_ready = 1'b0;
        exp_s = {1'b1, 1'b1, 1'b0, 4'd2, OP_NOP, 8'h02};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL async_pre: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== 21'h0) begin
            failures++;
            $display("FAIL async_rst_immediate: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, 21'h0);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_jump();
        logic [20:0] exp_s;
        acc_q.delete();
        load(4'd0, OP_LOADA, 8'h01);
        load(4'd1, OP_JMP,   8'h03);
        load(4'd2, OP_LOADB, 8'h09);
        load(4'd3, OP_HALT,  8'h00);
        instr_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        exp_s = {1'b1, 1'b1, 1'b0, 4'd0, OP_LOADA, 8'h01};
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL jump_first: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        tick();
`ifdef INSTR_SEQUENCER_JUMP_EN
        exp_s = {1'b0, 1'b1, 1'b0, 4'd3, OP_LOADA, 8'h01};
`else
        exp_s = {1'b1, 1'b1, 1'b0, 4'd1, OP_JMP, 8'h03};
`endif
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL jump_after_loada: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
        for (int i = 0; i < 40 && !done; i++) tick();
`ifdef INSTR_SEQUENCER_JUMP_EN
        exp_s = {1'b0, 1'b0, 1'b1, 4'd3, OP_LOADA, 8'h01};
`else
        exp_s = {1'b0, 1'b0, 1'b1, 4'd3, OP_LOADB, 8'h09};
`endif
        checks++;
        if ({instr_valid, busy, done, pc, opcode, operand} !== exp_s) begin
            failures++;
            $display("FAIL jump_halt: got %h expected %h",
                     {instr_valid, busy, done, pc, opcode, operand}, exp_s);
        end
`ifdef INSTR_SEQUENCER_JUMP_EN
        checks++;
        if (acc_q.size() != 1) begin
            failures++;
            $display("FAIL jump_accept_count: got %0d expected 1", acc_q.size());
        end
`else
        checks++;
        if (acc_q.size() != 3) begin
            failures++;
            $display("FAIL jump_accept_count: got %0d expected 3", acc_q.size());
        end else begin
            checks++;
            if ({acc_q[0], acc_q[1], acc_q[2]} !==
                {OP_LOADA, 8'h01, OP_JMP, 8'h03, OP_LOADB, 8'h09}) begin
                failures++;
                $display("FAIL jump_stream: got %h %h %h expected %h %h %h",
                         acc_q[0], acc_q[1], acc_q[2],
                         {OP_LOADA, 8'h01}, {OP_JMP, 8'h03}, {OP_LOADB, 8'h09});
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_write_drop();
        test_wrap();
        test_start_abort();
        test_async_rst();
        test_jump();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer that produces the opcode stream consumed by the tiny-RISC decoder.
- Holds a small loadable program memory and a program counter (PC).
- Issues one {opcode, operand} pair per accepted handshake, until it reaches a HALT word.
- Sits upstream of the decoder. The operand feeds the A/B register load path.

Parameters:
DEPTH, 16, program memory entries (power of two); ADDR_W = $clog2(DEPTH)
DATA_W, 8, operand width
OPCODE_W, 6, opcode width (fixed to the decoder's 6)

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
prog_we  in  1  program write strobe
prog_addr  in  ADDR_W  program write address
prog_wdata  in  OPCODE_W+DATA_W  word: {opcode, operand}, opcode in the MSBs
start  in  1  begin execution at address 0
abort  in  1  synchronous stop, return to IDLE
instr_ready  in  1  downstream accepts the current instruction
instr_valid  out  1  opcode/operand are valid
opcode  out  OPCODE_W  issued opcode
operand  out  DATA_W  issued operand
pc  out  ADDR_W  address of the currently presented instruction
busy  out  1  high in FETCH/ISSUE
done  out  1  high in HALT state

Behaviour:
- Reset (async): state=IDLE; pc=0; opcode=0; operand=0; instr_valid=0; busy=0; done=0. Memory contents are not reset.
- Opcodes: NOP=6'b000000, LOADA=000001, LOADB=000010, ADD=000011, READOUT=000100, JMP=000101, HALT=6'b111111. All except HALT (and JMP when the feature is enabled) are issued downstream unchanged.
- Memory write: prog_we is honoured only in IDLE or HALT, and takes effect at the clock edge. In FETCH/ISSUE, prog_we is silently dropped.
- IDLE:
  - start=1 → pc<=0, state FETCH, busy=1.
  - A write in HALT returns to IDLE and clears done.
- FETCH (1 cycle): read mem[pc] combinationally.
  - HALT word → state HALT, done=1, instr_valid stays 0.
  - Otherwise register opcode/operand, set instr_valid=1, state ISSUE.
  - Latency: start asserted at cycle N → instr_valid=1 at cycle N+2.
- ISSUE:
  - While instr_valid && !instr_ready, opcode/operand/pc hold stable.
  - On accept (instr_valid && instr_ready): pc<=pc+1, wrapping modulo DEPTH (DEPTH-1 → 0). In the same edge, load mem[pc+1].
    - Next word non-HALT → instr_valid stays 1. Throughput is one instruction per cycle.
    - Next word HALT → instr_valid<=0, state HALT, done=1, busy=0.
- HALT:
  - Outputs are held; instr_valid=0.
  - start=1 → restart (pc<=0, FETCH, done<=0).
- abort:
  - Any state → IDLE next edge; instr_valid<=0, busy<=0, done<=0, pc<=0.
  - abort has priority over start and over accept in the same cycle.
- start while busy is ignored.

Optional Feature:
- Macro: INSTR_SEQUENCER_JUMP_EN
- Defined: JMP is consumed internally and never issued. Jump target = operand[ADDR_W-1:0].
  - Fetched in FETCH, or next word at accept: pc<=target, stay/return to FETCH, instr_valid=0 for that cycle. This costs 1 bubble per jump.
  - JMP to itself loops forever, with instr_valid never asserted; abort exits.
- Undefined: JMP is issued downstream like any other non-HALT opcode, and pc increments normally.

Decomposition:
- risc_pkg:
  - opcode localparams OP_NOP, OP_LOADA, OP_LOADB, OP_ADD, OP_READOUT, OP_JMP, OP_HALT. The decoder also migrates to these.
  - typedef enum seq_state_t {IDLE, FETCH, ISSUE, HALT}.
- Sub-module prog_mem: DEPTH x (OPCODE_W+DATA_W) flop array with one synchronous write port and one asynchronous read port.

Test Plan:
- Load [LOADA 0x05, LOADB 0x07, ADD 0x00, HALT]; instr_ready=1; start → instr_valid at +2 cycles. Opcodes 01, 02, 03 issue on 3 consecutive cycles with operands 05, 07, 00. Then done=1, instr_valid=0, pc=3.
- Same program, instr_ready low for 4 cycles on the LOADB word → opcode=02, operand=07, pc=1 are stable all 4 cycles. Exactly 3 accepts total.
- DEPTH=16, no HALT, all NOP: pc wraps 15→0 without a bubble. Then abort → IDLE, pc=0, instr_valid=0 next edge.
- prog_we to addr 2 during ISSUE is dropped; mem[2] is unchanged (verified by later execution). A write in HALT clears done and returns to IDLE.
- start and abort in the same cycle from IDLE → stays IDLE. Async rst mid-ISSUE → all outputs zero immediately.
- With INSTR_SEQUENCER_JUMP_EN: [LOADA 1, JMP 0x03, LOADB 9, HALT] → issues 01 then HALT. 02 is never issued, with one bubble after LOADA. Without the macro: issues 01, 05, 02, then halts.
